// File: rtl/wishbone_slave_mux.sv
// wishbone_slave_mux
//   One-master / N-slave Wishbone classic interconnect. The slave index is taken
//   from the top SEL_W address bits. Exactly one transaction is in flight at a
//   time, and all master- and slave-side outputs are registered. Unmapped
//   indices are answered with m_err_o and ERR_PATTERN.
//
//   Optional feature macro: WB_MUX_TIMEOUT_EN. When it is defined, a slave
//   that does not ack within TIMEOUT_CYC BUSY cycles is released. The master
//   then receives an error.
//
// Ports
//   clk, rst_n                system clock, synchronous active-low reset
//   m_addr_i/m_we_i/m_data_i  master request (address, write enable, write data)
//   m_cyc_i/m_stb_i           master cycle / strobe
//   m_data_o                  read data (or ERR_PATTERN) to master, held until next response
//   m_ack_o/m_err_o           one-cycle completion / error pulses
//   s_cyc_o/s_stb_o           per-slave cycle/strobe (one-hot or zero)
//   s_we_o/s_addr_o/s_data_o  shared write enable, slave-local address, write data
//   s_data_i                  slave read data, slave k at [k*DATA_W +: DATA_W]
//   s_ack_i                   per-slave ack
module wishbone_slave_mux #(
  parameter int          NUM_SLAVES  = 2,
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 64,
  parameter int          SEL_W       = 4,
  parameter logic [63:0] ERR_PATTERN = 64'hDEAD_BEEF,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic                         m_we_i,
  input  logic [DATA_W-1:0]            m_data_i,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  output logic [DATA_W-1:0]            m_data_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_data_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || NUM_SLAVES > (1 << SEL_W) ||
      SEL_W > ADDR_W || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("wishbone_slave_mux: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   data_nx, wdat_nx, rdata;
  logic [ADDR_W-1:0]   addr_nx, req_addr;
  logic [SEL_W-1:0]    req_idx;
  logic [NUM_SLAVES-1:0] cyc_nx;
  logic                ack_nx, err_nx, we_nx, sel_ack;

`ifdef WB_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Zero outside BUSY, so every entry into BUSY starts the count from zero.
  always_ff @(posedge clk) begin
    if (!rst_n)             tmo_cnt <= '0;
    else if (state == BUSY) tmo_cnt <= tmo_cnt + CNT_W'(1);
    else                    tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  assign s_stb_o = s_cyc_o;

  // s_cyc_o is held one-hot on the selected slave throughout BUSY. It
  // therefore doubles as the ack mask and the read-data select, and no
  // separate index register is needed.
  assign sel_ack = |(s_ack_i & s_cyc_o);

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (s_cyc_o[k]) rdata = rdata | s_data_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    req_idx  = m_addr_i[ADDR_W-1 -: SEL_W];
    req_addr = m_addr_i;
    req_addr[ADDR_W-1 -: SEL_W] = '0;
  end

  always_comb begin
    state_nx = state;
    data_nx  = m_data_o;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    cyc_nx   = s_cyc_o;
    we_nx    = s_we_o;
    addr_nx  = s_addr_o;
    wdat_nx  = s_data_o;
    case (state)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          we_nx   = m_we_i;
          addr_nx = req_addr;
          wdat_nx = m_data_i;
          if (int'(req_idx) < NUM_SLAVES) begin
            cyc_nx   = NUM_SLAVES'(1) << req_idx;
            state_nx = BUSY;
          end else begin
            err_nx   = 1'b1;
            data_nx  = DATA_W'(ERR_PATTERN);
            state_nx = DONE;
          end
        end
      end
      BUSY: begin
        // Priority: abort, then ack, then timeout.
        if (!m_cyc_i) begin
          cyc_nx   = '0;
          state_nx = IDLE;
        end else if (sel_ack) begin
          data_nx  = rdata;
          cyc_nx   = '0;
          ack_nx   = 1'b1;
          state_nx = RESP;
        end
`ifdef WB_MUX_TIMEOUT_EN
        else if (tmo_hit) begin
          data_nx  = DATA_W'(ERR_PATTERN);
          cyc_nx   = '0;
          err_nx   = 1'b1;
          state_nx = RESP;
        end
`endif
      end
      RESP:    state_nx = DONE;
      DONE:    if (!m_stb_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_data_o <= '0;
      m_ack_o  <= 1'b0;
      m_err_o  <= 1'b0;
      s_cyc_o  <= '0;
      s_we_o   <= 1'b0;
      s_addr_o <= '0;
      s_data_o <= '0;
    end else begin
      state    <= state_nx;
      m_data_o <= data_nx;
      m_ack_o  <= ack_nx;
      m_err_o  <= err_nx;
      s_cyc_o  <= cyc_nx;
      s_we_o   <= we_nx;
      s_addr_o <= addr_nx;
      s_data_o <= wdat_nx;
    end
  end

endmodule
